// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC generation, credit-limited in-order fetch requests,
// and a small PC-tagged instruction queue feeding decode, with redirect flush.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW+1:0] W_DEPTH = (CW+2)'(DEPTH);

    logic [63:0]   r_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic [31:0]   r_q_inst [DEPTH];
    logic [63:0]   r_q_pc   [DEPTH];
    logic [AW-1:0] r_q_rd;
    logic [AW-1:0] r_q_wr;

    logic [63:0]   r_tag [DEPTH];
    logic [AW-1:0] r_tag_rd;
    logic [AW-1:0] r_tag_wr;

    logic [CW+1:0] w_credit_sum;
    logic          w_req_hs;
    logic          w_resp_ok;
    logic          w_resp_drop;
    logic          w_push;
    logic          w_pop;

    logic [63:0]   w_pc_nxt;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_drop_nxt;
    logic [AW-1:0] w_q_rd_nxt;
    logic [AW-1:0] w_q_wr_nxt;

    // Every request in flight or buffered holds a credit, so the queue cannot overflow.
    assign w_credit_sum   = {2'b00, r_outstanding} + {2'b00, r_count} + {2'b00, r_drop};
    assign imem_req_valid = !rst && !redirect_valid && (w_credit_sum < W_DEPTH);
    assign imem_req_addr  = r_pc;
    assign w_req_hs       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and pops no tag.
    assign w_resp_ok   = imem_resp_valid && ((r_outstanding != '0) || (r_drop != '0));
    assign w_resp_drop = imem_resp_valid && (r_drop != '0);
    assign w_push      = imem_resp_valid && !redirect_valid && (r_drop == '0)
                         && (r_outstanding != '0);

    assign inst_valid = (r_count != '0);
    assign w_pop      = inst_valid && inst_ready && !redirect_valid;
    assign inst       = inst_valid ? r_q_inst[r_q_rd] : 32'd0;
    assign inst_pc    = inst_valid ? r_q_pc[r_q_rd] : 64'd0;

    always_comb begin
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        w_out_nxt   = r_outstanding;
        w_drop_nxt  = r_drop;
        w_q_rd_nxt  = r_q_rd;
        w_q_wr_nxt  = r_q_wr;
        if (redirect_valid) begin
            w_pc_nxt    = redirect_pc & ~64'd3;
            w_count_nxt = '0;
            w_out_nxt   = '0;
            // Everything still in flight becomes stale, minus a response landing now.
            w_drop_nxt  = r_drop + r_outstanding - CW'(w_resp_ok);
            w_q_rd_nxt  = '0;
            w_q_wr_nxt  = '0;
        end else begin
            if (w_req_hs) begin
                w_pc_nxt = r_pc + 64'd4;
            end
            w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
            w_out_nxt   = r_outstanding + CW'(w_req_hs) - CW'(w_push);
            w_drop_nxt  = r_drop - CW'(w_resp_drop);
            if (w_push) begin
                w_q_wr_nxt = r_q_wr + AW'(1);
            end
            if (w_pop) begin
                w_q_rd_nxt = r_q_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_q_rd        <= '0;
            r_q_wr        <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_count       <= w_count_nxt;
            r_outstanding <= w_out_nxt;
            r_drop        <= w_drop_nxt;
            r_q_rd        <= w_q_rd_nxt;
            r_q_wr        <= w_q_wr_nxt;
            // Tag FIFO survives redirects so stale responses still retire their tags.
            if (w_req_hs) begin
                r_tag_wr <= r_tag_wr + AW'(1);
            end
            if (w_resp_ok) begin
                r_tag_rd <= r_tag_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_req_hs) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (!rst && w_push) begin
            r_q_inst[r_q_wr] <= imem_resp_data;
            r_q_pc[r_q_wr]   <= r_tag[r_tag_rd];
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized bench for ifu_fetch: a latency-configurable memory plus a
// transaction-level model of the fetch stream, checked every cycle.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    ifu_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem[$];
    logic [63:0] iq[$];
    int          lat;
    int          edge_n;
    logic [63:0] model_pc;
    logic [63:0] stream_pc;
    int          pops;
    int          n_chk;
    int          n_fail;
    logic        prev_v;
    logic        prev_r;
    logic        prev_hold_ok;
    logic [63:0] prev_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int live_count();
        int n = 0;
        foreach (mem[i]) if (!mem[i].stale) n++;
        return n;
    endfunction

    // Compare outputs against the model, then advance the model across the coming edge.
    task automatic sample_and_model();
        logic        exp_rv;
        logic [63:0] head_pc;
        mreq_t       h;
        exp_rv  = !rst && !redirect_valid && ((mem.size() + iq.size()) < DEPTH);
        head_pc = (iq.size() > 0) ? iq[0] : 64'd0;
        check_eq("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        check_eq("req_addr", imem_req_addr, model_pc);
        check_eq("inst_valid", 64'(inst_valid), 64'(iq.size() > 0));
        check_eq("inst_pc", inst_pc, head_pc);
        check_eq("inst", 64'(inst), {32'd0, head_pc[31:0]});
        if (prev_v && !prev_r && prev_hold_ok)
            check_eq("addr_hold", imem_req_addr, prev_addr);
        prev_v       = imem_req_valid;
        prev_r       = imem_req_ready;
        prev_addr    = imem_req_addr;
        prev_hold_ok = !rst && !redirect_valid;

        if (rst) begin
            mem.delete();
            iq.delete();
            model_pc  = RESET_PC;
            stream_pc = RESET_PC;
        end else if (redirect_valid) begin
            if (imem_resp_valid && mem.size() > 0) void'(mem.pop_front());
            foreach (mem[i]) mem[i].stale = 1'b1;
            iq.delete();
            model_pc  = redirect_pc & ~64'd3;
            stream_pc = model_pc;
        end else begin
            if (iq.size() > 0 && inst_ready) begin
                check_eq("stream_pc", inst_pc, stream_pc);
                check_eq("stream_inst", 64'(inst), {32'd0, stream_pc[31:0]});
                stream_pc = stream_pc + 64'd4;
                void'(iq.pop_front());
                pops++;
            end
            if (imem_resp_valid && mem.size() > 0) begin
                h = mem.pop_front();
                if (!h.stale) iq.push_back(h.addr);
            end
            if (exp_rv && imem_req_ready) begin
                h.addr  = model_pc;
                h.due   = edge_n + 1 + lat;
                h.stale = 1'b0;
                mem.push_back(h);
                model_pc = model_pc + 64'd4;
            end
        end
    endtask

    task automatic step();
        logic [63:0] a;
        @(negedge clk);
        sample_and_model();
        @(posedge clk);
        edge_n++;
        #1;
        imem_resp_valid = (mem.size() > 0) && (mem[0].due <= edge_n + 1);
        a = (mem.size() > 0) ? mem[0].addr : 64'd0;
        imem_resp_data = imem_resp_valid ? a[31:0] : 32'hdead_beef;
    endtask

    initial begin
        int t;
        n_chk = 0; n_fail = 0; pops = 0; edge_n = 0; lat = 1;
        prev_v = 1'b0; prev_r = 1'b0; prev_hold_ok = 1'b0; prev_addr = '0;
        model_pc = RESET_PC; stream_pc = RESET_PC;
        rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check_eq("first_addr", imem_req_addr, 64'h8000_0000);

        // Streaming with single-cycle memory.
        repeat (30) step();

        // Decode backpressure.
        inst_ready = 1'b0;
        repeat (10) step();
        check_eq("bp_req_valid", 64'(imem_req_valid), 64'd0);
        inst_ready = 1'b1;
        repeat (10) step();

        // Redirect with two requests in flight.
        lat = 3;
        t = 0;
        while (live_count() < 2 && t < 50) begin step(); t++; end
        check_eq("wait_inflight2", 64'(live_count() >= 2), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1002;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_addr", imem_req_addr, 64'h8000_1000);
        check_eq("redir_flush", 64'(inst_valid), 64'd0);
        repeat (15) step();

        // Redirect coinciding with a response and a ready decode stage.
        lat = 1;
        t = 0;
        while (!(imem_resp_valid && iq.size() > 0) && t < 50) begin step(); t++; end
        check_eq("wait_resp_head", 64'(imem_resp_valid && iq.size() > 0), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_resp_flush", 64'(inst_valid), 64'd0);
        repeat (10) step();

        // Random memory readiness, 3-cycle latency, occasional random redirects.
        lat = 3;
        pops = 0;
        t = 0;
        while (pops < 1000 && t < 20000) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = {32'd0, $urandom};
            step();
            t++;
        end
        redirect_valid = 1'b0;
        check_eq("rand_pops_done", 64'(pops >= 1000), 64'd1);

        // Reset mid-stream with one request in flight.
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 2;
        t = 0;
        while (mem.size() != 1 && t < 50) begin step(); t++; end
        check_eq("wait_inflight1", 64'(mem.size()), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_inst_pc", inst_pc, 64'd0);
        check_eq("rst_addr", imem_req_addr, RESET_PC);
        pops = 0;
        repeat (20) step();
        check_eq("rst_restart", 64'(pops > 0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit feeding the decode stage. It holds the PC and issues in-order fetch requests to instruction memory over a valid/ready request channel. Returned 32-bit instructions are buffered in a small queue, each paired with its PC, and presented to decode through a valid/ready handshake. A redirect input, such as a branch or jump resolved downstream, flushes the queue, discards stale in-flight responses and restarts fetch at the new PC.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC after reset
DEPTH, 2, instruction queue entries; also the maximum number of in-flight requests plus buffered entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address, 4-byte aligned
imem_resp_valid  in  1  response valid; responses arrive in order, ≥1 cycle after acceptance, always accepted
imem_resp_data  in  32  instruction word
redirect_valid  in  1  flush and restart
redirect_pc  in  64  new PC; bits [1:0] ignored (treated as 0)
inst_valid  out  1  queue head valid to decode
inst_ready  in  1  decode consumes head
inst  out  32  head instruction
inst_pc  out  64  PC of head instruction

Behaviour:
- Reset (rst high at a clk edge, synchronous, active-high; clock clk):
  - pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - Outputs: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, imem_req_addr=RESET_PC.
  - Reset mid-operation abandons all in-flight requests; responses to them must not enter the queue. Memory is reset together with this block.
- Credit rule: imem_req_valid = !rst && !redirect_valid && (outstanding + count + drop_cnt < DEPTH). It is combinational from registered state plus redirect_valid.
- imem_req_addr = pc.
- Request handshake (valid && ready):
  - pc <= pc+4, 64-bit wrap.
  - The issued pc is pushed into a pc-tag FIFO.
  - outstanding increments.
- Address stability: while valid && !ready, addr stays stable. The sole exception is redirect, which may deassert valid and change addr next cycle.
- Response (imem_resp_valid):
  - If drop_cnt>0: drop_cnt decrements, data is discarded, and the pc-tag is popped.
  - Otherwise: data is pushed into the queue with the popped pc-tag, and outstanding decrements.
  - The credit rule guarantees the queue never overflows. A response arriving with outstanding=0 and drop_cnt=0 is a protocol error and is ignored.
- Output: inst_valid = count>0. inst/inst_pc show the head entry, and are 0 when empty. On inst_valid && inst_ready the head is popped.
- Simultaneous events:
  - Push and pop in the same cycle leaves count unchanged.
  - Pushing into an empty queue makes inst_valid appear the next cycle. There is no combinational resp-to-inst bypass, so minimum latency is request accept → response → inst_valid +1 cycle.
  - A request handshake and a response in the same cycle update outstanding by net 0.
- Redirect (redirect_valid at the edge, priority over everything except rst):
  - The queue is flushed, and a pop in the same cycle is ignored.
  - pc <= {redirect_pc[63:2],2'b00}.
  - No request handshake occurs that cycle.
  - drop_cnt <= drop_cnt + outstanding − (1 if a response arrives that cycle, else 0); outstanding <= 0.
  - A same-cycle response is discarded.
  - The pc-tag FIFO is kept, so dropped responses still pop their tags.
  - Back-to-back redirects accumulate drop_cnt correctly.
- Counters: count width log2(DEPTH)+1; outstanding and drop_cnt share the same width.

Test Plan:
- Reset, imem_req_ready=1, 1-cycle memory returning addr[31:0] as data, inst_ready=1 → first request addr 0x80000000. The stream is inst_pc 0x80000000, 0x80000004, 0x80000008… with inst matching, in order and gapless after warm-up.
- Backpressure: inst_ready=0 for 10 cycles → at most DEPTH=2 in flight plus buffered. imem_req_valid drops to 0, no entry is lost or duplicated, and the sequence resumes at the correct PC after ready=1.
- Redirect to 0x80001002 with 2 requests in flight → the queue empties the next cycle and both stale responses are discarded. Next issued addr is 0x80001000, and the first inst_pc after the redirect is 0x80001000.
- Redirect in the same cycle as a response and inst_ready=1 → no pop of the stale head and the response is dropped. drop_cnt is correct, with no stale inst_valid afterward.
- imem_req_ready random 50% with 3-cycle response latency for 1000 instructions → inst_pc strictly increments by 4 between redirects, and addr is held stable while valid && !ready.
- Reset asserted mid-stream with one request in flight → all outputs return to reset values the next cycle, and fetch restarts at 0x80000000.
